// File: rtl/ts_pkg.sv
// Shared constants, FSM encoding and tag helper for the TS ingest arbiter.
package ts_pkg;

  localparam int TS_DESC_WORDS    = 4;
  localparam int TS_PAYLOAD_WORDS = 47;
  localparam int TS_PKT_WORDS     = TS_DESC_WORDS + TS_PAYLOAD_WORDS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // Channel tag written into the low byte of descriptor word 0 (wraps mod 256).
  function automatic logic [7:0] ts_tag(input logic [7:0] base, input logic [2:0] port);
    return base + {5'd0, port};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: the first set request at or after start_i wins.
module rr_pick import ts_pkg::*; #(
  parameter int N_PORTS = 4
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [2:0]         start_i,
  output logic               valid_o,
  output logic [2:0]         idx_o
);

  logic [7:0] req8_s;
  logic [3:0] pos_s;

  assign req8_s = 8'(req_i);

  // Walk the ring from the far end back to start so the nearest candidate is written last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = 3'd0;
    pos_s   = 4'd0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      pos_s = {1'b0, start_i} + 4'(i);
      if (pos_s >= 4'(N_PORTS)) begin
        pos_s = pos_s - 4'(N_PORTS);
      end else begin
        pos_s = pos_s;
      end
      if (req8_s[pos_s[2:0]]) begin
        valid_o = 1'b1;
        idx_o   = pos_s[2:0];
      end else begin
        valid_o = valid_o;
        idx_o   = idx_o;
      end
    end
  end

endmodule

// File: rtl/ts_in_arb.sv
// Packet-granular round-robin arbiter feeding the single CSA ingest port from N channel FIFOs.
module ts_in_arb import ts_pkg::*; #(
  parameter int         N_PORTS    = 4,
  parameter int         PKT_WORDS  = TS_PKT_WORDS,
  parameter int         GAP_CYCLES = 6,
  parameter bit         TAG_EN     = 1'b1,
  parameter logic [7:0] TAG_BASE   = 8'h01
) (
  input  logic                    clk_main,
  input  logic                    rst,
  input  logic [N_PORTS*32-1:0]   port_din,
  input  logic [N_PORTS-1:0]      port_pkt_rdy,
  input  logic [N_PORTS-1:0]      port_en,
  output logic [N_PORTS-1:0]      port_rd,
  output logic [31:0]             ts_dout,
  output logic                    ts_dout_en,
  output logic [2:0]              cur_port,
  output logic                    busy,
  output logic [15:0]             pkt_count
);

  localparam logic [5:0] LAST_WORD = 6'(PKT_WORDS - 1);
  localparam logic [7:0] GAP_LAST  = (GAP_CYCLES >= 2) ? 8'(GAP_CYCLES - 2) : 8'd0;

  arb_state_e          state_q, state_d;
  logic [2:0]          grant_q, grant_d;
  logic [2:0]          cur_port_q, cur_port_d;
  logic [5:0]          wcnt_q, wcnt_d;
  logic [7:0]          gcnt_q, gcnt_d;
  logic [N_PORTS-1:0]  port_rd_q, port_rd_d;
  logic [15:0]         pkt_count_q, pkt_count_d;
  logic                busy_q;
  logic                rd_dly_q;
  logic                first_q;
  logic [31:0]         ts_dout_q, ts_dout_d;
  logic                ts_dout_en_q, ts_dout_en_d;

  logic [2:0]          start_s;
  logic                pick_valid_s;
  logic [2:0]          pick_idx_s;
  logic [31:0]         din_sel_s;

  function automatic logic [N_PORTS-1:0] onehot(input logic [2:0] idx);
    logic [7:0] v;
    v = 8'd1 << idx;
    return v[N_PORTS-1:0];
  endfunction

  assign start_s = (cur_port_q == 3'(N_PORTS - 1)) ? 3'd0 : cur_port_q + 3'd1;

  rr_pick #(.N_PORTS(N_PORTS)) u_pick (
    .req_i   (port_pkt_rdy & port_en),
    .start_i (start_s),
    .valid_o (pick_valid_s),
    .idx_o   (pick_idx_s)
  );

  // Read-data mux for the granted channel.
  always_comb begin
    din_sel_s = 32'd0;
    for (int k = 0; k < N_PORTS; k++) begin
      din_sel_s = (grant_q == 3'(k)) ? port_din[32*k +: 32] : din_sel_s;
    end
  end

  // Next-state logic: grant in IDLE, pop PKT_WORDS words in READ, hold off in GAP.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cur_port_d  = cur_port_q;
    wcnt_d      = wcnt_q;
    gcnt_d      = gcnt_q;
    port_rd_d   = '0;
    pkt_count_d = pkt_count_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          grant_d    = pick_idx_s;
          cur_port_d = pick_idx_s;
          wcnt_d     = 6'd0;
          port_rd_d  = onehot(pick_idx_s);
          state_d    = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        // wcnt_q is the index of the word being popped this cycle.
        if (wcnt_q == LAST_WORD) begin
          pkt_count_d = pkt_count_q + 16'd1;
          gcnt_d      = 8'd0;
          state_d     = (GAP_CYCLES == 1) ? ST_IDLE : ST_GAP;
        end else begin
          wcnt_d    = wcnt_q + 6'd1;
          port_rd_d = onehot(grant_q);
        end
      end
      ST_GAP: begin
        if (gcnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output word: FIFO data lands one cycle after the pop and is registered here.
  always_comb begin
    ts_dout_d    = ts_dout_q;
    ts_dout_en_d = 1'b0;
    if (rd_dly_q) begin
      ts_dout_d    = {din_sel_s[31:8],
                      (TAG_EN && first_q) ? ts_tag(TAG_BASE, grant_q) : din_sel_s[7:0]};
      ts_dout_en_d = 1'b1;
    end else begin
      ts_dout_d    = ts_dout_q;
      ts_dout_en_d = 1'b0;
    end
  end

  // State and datapath registers; reset abandons any packet in flight.
  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 3'd0;
      cur_port_q   <= 3'(N_PORTS - 1);
      wcnt_q       <= 6'd0;
      gcnt_q       <= 8'd0;
      port_rd_q    <= '0;
      pkt_count_q  <= 16'd0;
      busy_q       <= 1'b0;
      rd_dly_q     <= 1'b0;
      first_q      <= 1'b0;
      ts_dout_q    <= 32'd0;
      ts_dout_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      cur_port_q   <= cur_port_d;
      wcnt_q       <= wcnt_d;
      gcnt_q       <= gcnt_d;
      port_rd_q    <= port_rd_d;
      pkt_count_q  <= pkt_count_d;
      busy_q       <= (state_d != ST_IDLE);
      rd_dly_q     <= |port_rd_q;
      first_q      <= (state_q == ST_READ) && (wcnt_q == 6'd0);
      ts_dout_q    <= ts_dout_d;
      ts_dout_en_q <= ts_dout_en_d;
    end
  end

  assign port_rd    = port_rd_q;
  assign ts_dout    = ts_dout_q;
  assign ts_dout_en = ts_dout_en_q;
  assign cur_port   = cur_port_q;
  assign busy       = busy_q;
  assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_ts_in_arb.sv
// Directed bench: three arbiter instances (default, tagging off, one-cycle gap) with FIFO models.
module tb_ts_in_arb;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   rdy = 4'd0;
  logic [3:0]   en  = 4'hF;
  logic [127:0] din  [3];
  logic [3:0]   prd  [3];
  logic [31:0]  dout [3];
  logic         den  [3];
  logic [2:0]   curp [3];
  logic         bsy  [3];
  logic [15:0]  pcnt [3];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int pops [3][4];

  int run [3], idle [3], errs [3], mon_port [3], cur_start [3], cur_gap [3], nrec [3];
  logic [31:0] cur_first [3];
  int rec_port [3][16], rec_len [3][16], rec_start [3][16], rec_gap [3][16], rec_err [3][16];
  logic [31:0] rec_first [3][16];
  int blow [3], nbl [3];
  int blen [3][16];

  always #5 clk = ~clk;

  ts_in_arb u_dut (
    .clk_main(clk), .rst(rst), .port_din(din[0]), .port_pkt_rdy(rdy), .port_en(en),
    .port_rd(prd[0]), .ts_dout(dout[0]), .ts_dout_en(den[0]), .cur_port(curp[0]),
    .busy(bsy[0]), .pkt_count(pcnt[0]));

  ts_in_arb #(.TAG_EN(1'b0)) u_nt (
    .clk_main(clk), .rst(rst), .port_din(din[1]), .port_pkt_rdy(rdy), .port_en(en),
    .port_rd(prd[1]), .ts_dout(dout[1]), .ts_dout_en(den[1]), .cur_port(curp[1]),
    .busy(bsy[1]), .pkt_count(pcnt[1]));

  ts_in_arb #(.GAP_CYCLES(1)) u_g1 (
    .clk_main(clk), .rst(rst), .port_din(din[2]), .port_pkt_rdy(rdy), .port_en(en),
    .port_rd(prd[2]), .ts_dout(dout[2]), .ts_dout_en(den[2]), .cur_port(curp[2]),
    .busy(bsy[2]), .pkt_count(pcnt[2]));

  // Word w of a packet from port p; word 0 is a bare descriptor value 5.
  function automatic logic [31:0] word_of(input logic [7:0] p, input int w);
    if (w == 0) return 32'h0000_0005;
    else return {8'hA0, p, 8'h00, 8'(w)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models: data for a pop appears the cycle after the pop.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        din[i] <= 128'd0;
        for (int k = 0; k < 4; k++) pops[i][k] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (prd[i][k]) begin
            din[i][32*k +: 32] <= word_of(8'(k), pops[i][k] % 51);
            pops[i][k] <= pops[i][k] + 1;
          end
        end
      end
    end
  end

  // Burst monitor: records port, length, start cycle, preceding gap, word errors, busy-low runs.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        run[i] <= 0; idle[i] <= 0; nrec[i] <= 0; errs[i] <= 0; blow[i] <= 0; nbl[i] <= 0;
      end else begin
        if (den[i]) begin
          run[i] <= run[i] + 1;
          idle[i] <= 0;
          if (run[i] == 0) begin
            cur_start[i] <= cyc; cur_first[i] <= dout[i]; cur_gap[i] <= idle[i]; errs[i] <= 0;
          end else if (run[i] == 1) begin
            mon_port[i] <= int'(dout[i][23:16]);
            errs[i] <= errs[i] + ((dout[i] !== word_of(dout[i][23:16], 1)) ? 1 : 0);
          end else begin
            errs[i] <= errs[i] + ((dout[i] !== word_of(8'(mon_port[i]), run[i])) ? 1 : 0);
          end
        end else begin
          idle[i] <= idle[i] + 1;
          if (run[i] > 0) begin
            if (nrec[i] < 16) begin
              rec_port[i][nrec[i]]  <= mon_port[i];
              rec_len[i][nrec[i]]   <= run[i];
              rec_start[i][nrec[i]] <= cur_start[i];
              rec_gap[i][nrec[i]]   <= cur_gap[i];
              rec_err[i][nrec[i]]   <= errs[i];
              rec_first[i][nrec[i]] <= cur_first[i];
            end
            nrec[i] <= nrec[i] + 1;
            run[i] <= 0;
          end
        end
        if (!bsy[i]) blow[i] <= blow[i] + 1;
        else if (blow[i] > 0) begin
          if (nbl[i] < 16) blen[i][nbl[i]] <= blow[i];
          nbl[i] <= nbl[i] + 1;
          blow[i] <= 0;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rdy = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_recs(input int i, input int n, input string tag);
    int k = 0;
    while (nrec[i] < n && k < 2000) begin @(negedge clk); k++; end
    @(negedge clk);
    check(tag, 32'(nrec[i] >= n), 32'd1);
  endtask

  task automatic wait_pops(input int i, input int p, input int n, input string tag);
    int k = 0;
    while (pops[i][p] < n && k < 2000) begin @(negedge clk); k++; end
    check(tag, 32'(pops[i][p] >= n), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    int k;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_port_rd", 32'(prd[0]), 32'd0);
    check("rst_dout", dout[0], 32'd0);
    check("rst_dout_en", 32'(den[0]), 32'd0);
    check("rst_cur_port", 32'(curp[0]), 32'd3);
    check("rst_busy", 32'(bsy[0]), 32'd0);
    check("rst_pkt_count", 32'(pcnt[0]), 32'd0);

    // Single port 2, defaults and tagging-off instance in parallel.
    rdy = 4'b0100;
    c0 = cyc;
    @(negedge clk);
    check("t1_grant_rd", 32'(prd[0]), 32'h4);
    rdy = 4'b0000;
    wait_recs(0, 1, "t1_wait");
    check("t1_len", 32'(rec_len[0][0]), 32'd51);
    check("t1_start", 32'(rec_start[0][0]), 32'(c0 + 3));
    check("t1_port", 32'(rec_port[0][0]), 32'd2);
    check("t1_word0_tag", rec_first[0][0], 32'h0000_0003);
    check("t1_word_errs", 32'(rec_err[0][0]), 32'd0);
    check("t1_pkt_count", 32'(pcnt[0]), 32'd1);
    check("t1_pops", 32'(pops[0][2]), 32'd51);
    check("t1_cur_port", 32'(curp[0]), 32'd2);
    check("t4_notag_word0", rec_first[1][0], 32'h0000_0005);
    check("t4_notag_len", 32'(rec_len[1][0]), 32'd51);
    repeat (10) @(negedge clk);
    check("t1_idle_busy", 32'(bsy[0]), 32'd0);

    // All ports ready: order 0,1,2,3,0 with 6-cycle gaps and 57-cycle period.
    do_reset();
    rdy = 4'hF;
    wait_recs(0, 5, "t2_wait");
    for (int j = 0; j < 5; j++) begin
      check($sformatf("t2_port%0d", j), 32'(rec_port[0][j]), 32'(j % 4));
      check($sformatf("t2_len%0d", j), 32'(rec_len[0][j]), 32'd51);
      check($sformatf("t2_err%0d", j), 32'(rec_err[0][j]), 32'd0);
    end
    for (int j = 1; j < 5; j++) begin
      check($sformatf("t2_gap%0d", j), 32'(rec_gap[0][j]), 32'd6);
      check($sformatf("t2_period%0d", j), 32'(rec_start[0][j] - rec_start[0][j-1]), 32'd57);
    end

    // Port 2 disabled; drop port_en[1] in the middle of the port 1 packet.
    en = 4'b1011;
    do_reset();
    rdy = 4'hF;
    wait_pops(0, 1, 10, "t3_wait_p1");
    en = 4'b1001;
    wait_recs(0, 4, "t3_wait");
    check("t3_port0", 32'(rec_port[0][0]), 32'd0);
    check("t3_port1", 32'(rec_port[0][1]), 32'd1);
    check("t3_len1", 32'(rec_len[0][1]), 32'd51);
    check("t3_port2", 32'(rec_port[0][2]), 32'd3);
    check("t3_port3", 32'(rec_port[0][3]), 32'd0);
    check("t3_no_pop2", 32'(pops[0][2]), 32'd0);
    en = 4'hF;

    // Reset at word 20 of the second port 1 packet.
    do_reset();
    rdy = 4'b0010;
    wait_pops(0, 1, 71, "t5_wait_pops");
    check("t5_pre_pkt_count", 32'(pcnt[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_port_rd", 32'(prd[0]), 32'd0);
    check("t5_rst_dout", dout[0], 32'd0);
    check("t5_rst_dout_en", 32'(den[0]), 32'd0);
    check("t5_rst_busy", 32'(bsy[0]), 32'd0);
    check("t5_rst_pkt_count", 32'(pcnt[0]), 32'd0);
    check("t5_rst_cur_port", 32'(curp[0]), 32'd3);
    rdy = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (prd[0] == 4'd0 && k < 20) begin @(negedge clk); k++; end
    check("t5_first_grant", 32'(prd[0]), 32'h1);
    check("t5_pkt_restart", 32'(pcnt[0]), 32'd0);
    wait_recs(0, 1, "t5_wait");
    check("t5_first_port", 32'(rec_port[0][0]), 32'd0);

    // One-cycle gap instance with two ports ready.
    do_reset();
    rdy = 4'b0011;
    wait_recs(2, 3, "t6_wait");
    check("t6_port0", 32'(rec_port[2][0]), 32'd0);
    check("t6_port1", 32'(rec_port[2][1]), 32'd1);
    check("t6_port2", 32'(rec_port[2][2]), 32'd0);
    check("t6_gap1", 32'(rec_gap[2][1]), 32'd1);
    check("t6_gap2", 32'(rec_gap[2][2]), 32'd1);
    check("t6_len1", 32'(rec_len[2][1]), 32'd51);
    check("t6_word0_tag", rec_first[2][1], 32'h0000_0002);
    check("t6_busy_low_runs", 32'(nbl[2] >= 2), 32'd1);
    check("t6_busy_low_len", 32'(blen[2][1]), 32'd1);
    rdy = 4'd0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
